// File: rtl/corefifo_pkg.sv
// Shared CoreFIFO helpers: depth derivation and Gray/binary pointer conversion,
// used by both the write-side and read-side controllers.
package corefifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int corefifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Callers zero-extend narrower pointers and truncate the result, so one body
  // serves every pointer width up to PTR_MAX_W.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Log-step XOR prefix from the MSB down: bin[i] = ^gray[W-1:i].
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = g;
    for (int s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary converter for a synchronized FIFO pointer.
module corefifo_gray2bin
  import corefifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(gray2bin(ptr_max_t'(gray_i)));

endmodule

// File: rtl/corefifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the dual-clock CoreFIFO:
// RAM write address/enable, Gray write pointer, full/afull/overflow, fill count.
module corefifo_wr_ctrl
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic                 overflow,
  output logic [ADDRWIDTH:0]   wr_cnt
);

  localparam int               PTR_W   = ADDRWIDTH + 1;
  localparam int               DEPTH   = corefifo_depth(ADDRWIDTH);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_C = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rbin;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             wr_accept;

  corefifo_gray2bin #(
    .W(PTR_W)
  ) u_rd_gray2bin (
    .gray_i(rd_ptr_gray_sync),
    .bin_o (rbin)
  );

  assign wr_accept = wr_en & ~full_q;

  // Flags are computed from the post-write pointer so an accepted write shows
  // up in wr_cnt/full/afull on the same edge that advances the pointer.
  always_comb begin
    wbin_d  = wr_accept ? wbin_q + PTR_W'(1) : wbin_q;
    wgray_d = PTR_W'(bin2gray(ptr_max_t'(wbin_d)));
    cnt_d   = wbin_d - rbin;
    full_d  = (cnt_d >= DEPTH_C);
    afull_d = (cnt_d >= AFULL_C);
    ovf_d   = wr_en & full_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // wr_ptr_gray crosses clock domains, so it comes straight off a flop.
  assign wr_ptr_gray = wgray_q;
  assign mem_we      = wr_accept;
  assign wr_addr     = wbin_q[ADDRWIDTH-1:0];
  assign full        = full_q;
  assign afull       = afull_q;
  assign overflow    = ovf_q;
  assign wr_cnt      = cnt_q;

endmodule

// File: tb/tb_corefifo_wr_ctrl.sv
// Scoreboard bench for corefifo_wr_ctrl (ADDRWIDTH=3, AFULL_THRESH=6).
`timescale 1ns/1ps
module tb_corefifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       srst;
  logic       wr_en;
  logic [3:0] rd_gray;
  logic       mem_we;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       afull;
  logic       overflow;
  logic [3:0] wr_cnt;

  corefifo_wr_ctrl #(
    .ADDRWIDTH   (3),
    .AFULL_THRESH(6)
  ) dut (
    .clk             (clk),
    .srst            (srst),
    .wr_en           (wr_en),
    .rd_ptr_gray_sync(rd_gray),
    .mem_we          (mem_we),
    .wr_addr         (wr_addr),
    .wr_ptr_gray     (wr_ptr_gray),
    .full            (full),
    .afull           (afull),
    .overflow        (overflow),
    .wr_cnt          (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       we;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  // Hand-written 4-bit Gray sequence for binary 0..15.
  logic [3:0] gray16 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

  logic       ham_en    = 1'b0;
  logic       ham_valid = 1'b0;
  logic [3:0] ham_prev  = 4'b0000;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s vec%0d: got %0h expected %0h", nm, id, act, exp);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs just after the edge and queue what the outputs
  // must read mid-cycle (registers from prior edges, mem_we from these inputs).
  task automatic v(input logic s, input logic w, input logic [3:0] rg,
                   input logic ewe, input logic [2:0] ea, input logic [3:0] eg,
                   input logic ef, input logic eaf, input logic eo,
                   input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    srst    = s;
    wr_en   = w;
    rd_gray = rg;
    e.id    = vec_id;
    e.we    = ewe;
    e.addr  = ea;
    e.gray  = eg;
    e.full  = ef;
    e.afull = eaf;
    e.ovf   = eo;
    e.cnt   = ec;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic drive_only(input logic s, input logic w, input logic [3:0] rg);
    @(posedge clk);
    #1;
    srst    = s;
    wr_en   = w;
    rd_gray = rg;
  endtask

  task automatic fill8();
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd1);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 1'b0, 4'd2);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd3);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 1'b0, 4'd4);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 1'b0, 4'd5);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b1, 1'b0, 4'd6);
    v(1'b0, 1'b1, 4'b0000, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd7);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("mem_we",      e.id, 32'(mem_we),      32'(e.we));
      chk("wr_addr",     e.id, 32'(wr_addr),     32'(e.addr));
      chk("wr_ptr_gray", e.id, 32'(wr_ptr_gray), 32'(e.gray));
      chk("full",        e.id, 32'(full),        32'(e.full));
      chk("afull",       e.id, 32'(afull),       32'(e.afull));
      chk("overflow",    e.id, 32'(overflow),    32'(e.ovf));
      chk("wr_cnt",      e.id, 32'(wr_cnt),      32'(e.cnt));
    end
  end

  always @(negedge clk) begin
    if (!ham_en) begin
      ham_valid = 1'b0;
    end else begin
      if (ham_valid) begin
        int hd;
        hd = $countones(wr_ptr_gray ^ ham_prev);
        n_checks++;
        if (hd > 1)
          $display("FAIL gray_hamming: %b -> %b distance %0d required <=1",
                   ham_prev, wr_ptr_gray, hd);
        else
          n_pass++;
      end
      ham_prev  = wr_ptr_gray;
      ham_valid = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    srst    = 1'b1;
    wr_en   = 1'b1;
    rd_gray = 4'b0000;

    // Reset with wr_en held high: pointer stays 0, mem_we still follows wr_en.
    v(1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    v(1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // Fill to full, then two rejected writes.
    fill8();
    v(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b0, 4'd8);
    v(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd8);
    v(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd8);

    // Drain release: read pointer to binary 2, two writes accepted.
    v(1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b0, 4'd8);
    v(1'b0, 1'b1, 4'b0011, 1'b1, 3'd0, 4'b1100, 1'b0, 1'b1, 1'b0, 4'd6);
    v(1'b0, 1'b1, 4'b0011, 1'b1, 3'd1, 4'b1101, 1'b0, 1'b1, 1'b0, 4'd7);
    v(1'b0, 1'b0, 4'b0011, 1'b0, 3'd2, 4'b1111, 1'b1, 1'b1, 1'b0, 4'd8);

    // Multi-step read jump 0 -> 4 from full.
    drive_only(1'b1, 1'b0, 4'b0000);
    fill8();
    v(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b0, 4'd8);
    v(1'b0, 1'b0, 4'b0110, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 1'b0, 4'd8);
    v(1'b0, 1'b0, 4'b0110, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'd4);
    v(1'b0, 1'b1, 4'b0110, 1'b1, 3'd0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'd4);
    v(1'b0, 1'b0, 4'b0110, 1'b0, 3'd1, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd5);

    // Wrap: 20 writes with the read pointer one behind the write pointer.
    drive_only(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      v(1'b0, 1'b1, gray16[i % 16], 1'b1, 3'(i % 8), gray16[i % 16],
        1'b0, 1'b0, 1'b0, (i == 0) ? 4'd0 : 4'd1);
      if (i == 0) ham_en = 1'b1;
    end
    v(1'b0, 1'b0, gray16[4], 1'b0, 3'd4, gray16[4], 1'b0, 1'b0, 1'b0, 4'd1);

    // Random write requests with occasional full drains; Gray steps checked.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      srst  = 1'b0;
      wr_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rd_gray = wr_ptr_gray;
    end

    @(posedge clk);
    #1;
    ham_en = 1'b0;
    wr_en  = 1'b0;
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
